// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and feeder FSM encoding for the SD sector feeder
// Purpose: sector geometry, default start address / sector limit, feeder state type.
// Ports: none (package).
package sd_pkg;

    localparam int          SECTOR_WORDS_DEF = 256;
    localparam int          FIFO_DEPTH_DEF   = 512;
    localparam logic [31:0] START_ADDR_DEF   = 32'd2048;
    localparam logic [31:0] MAX_SECTORS_DEF  = 32'd1048576;
    // Cycles spent waiting for wr_busy before the write start is re-pulsed.
    localparam int          BSY_TIMEOUT      = 16;

    typedef enum logic [2:0] {
        F_IDLE      = 3'd0,
        F_ISSUE     = 3'd1,
        F_WAIT_BSY  = 3'd2,
        F_WAIT_DONE = 3'd3,
        F_ADV       = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/sd_sector_feeder_if.sv
// rtl/sd_sector_feeder_if.sv - sample stream and SD writer handshake bundle
// Purpose: groups the input sample stream and the writer-side signals of the feeder.
// Ports: din_valid/din/din_ready (sample stream), wr_busy/wr_req/wr_en/wr_addr/wr_data (writer).
//   master: the feeder; slave: the producer + writer side.
interface sd_sector_feeder_if;

    logic        din_valid;
    logic [15:0] din;
    logic        din_ready;
    logic        wr_busy;
    logic        wr_req;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;

    modport master (
        input  din_valid, din, wr_busy, wr_req,
        output din_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output din_valid, din, wr_busy, wr_req,
        input  din_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/sd_wr_fifo.sv
// rtl/sd_wr_fifo.sv - synchronous FIFO with registered read for the sector feeder
// Purpose: buffers sample words; the head is registered into dout on each pop.
// Ports: clk, rst (sync active-high), push/din, pop/dout, full, empty, count.
//   A push while full is still accepted when a pop happens in the same cycle.
//   A pop while empty loads all-ones into dout and leaves the pointers alone.
module sd_wr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (pop) begin
                dout   <= '1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/sd_sector_feeder.sv
// rtl/sd_sector_feeder.sv - buffers samples and launches one SD block write per 256 words
// Purpose: 2-sector FIFO in front of the SD single-block writer, with an auto-incrementing
//   sector address, sector limit and sticky error flag.
// Ports: sys_clk, sys_rst (sync active-high), init_end (card ready),
//   bus (master: din stream in, wr_en/wr_addr/wr_data out, wr_busy/wr_req in),
//   overflow (sticky dropped word / empty pop), log_full (sector limit reached).
module sd_sector_feeder
    import sd_pkg::*;
#(
    parameter int          SECTOR_WORDS = SECTOR_WORDS_DEF,
    parameter int          FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter logic [31:0] START_ADDR   = START_ADDR_DEF,
    parameter logic [31:0] MAX_SECTORS  = MAX_SECTORS_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               init_end,
    sd_sector_feeder_if.master bus,
    output logic               overflow,
    output logic               log_full
);

    localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] SECTOR_CNT = CW'(SECTOR_WORDS);
    localparam logic [3:0]    TMO_LAST   = 4'(BSY_TIMEOUT - 1);

    feeder_state_t state;
    feeder_state_t state_nxt;
    logic [3:0]    bsy_tmo;
    logic [31:0]   sector_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          drop;
    logic          underrun;

    assign bus.din_ready = !fifo_full;

    // A word offered while full is lost unless a pop frees the slot in the same cycle.
    assign drop     = bus.din_valid && fifo_full && !(bus.wr_req && !fifo_empty);
    assign underrun = bus.wr_req && fifo_empty;

    sd_wr_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (bus.din_valid),
        .din   (bus.din),
        .pop   (bus.wr_req),
        .dout  (bus.wr_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sectors are only issued from F_IDLE, where nothing is owed to an in-flight
    // write, so the raw FIFO count is the available word count there.
    always_comb begin
        state_nxt  = state;
        bus.wr_en  = 1'b0;
        case (state)
            F_IDLE: begin
                if (init_end && !bus.wr_busy && !log_full && fifo_count >= SECTOR_CNT) begin
                    state_nxt = F_ISSUE;
                end
            end
            F_ISSUE: begin
                bus.wr_en = 1'b1;
                state_nxt = F_WAIT_BSY;
            end
            F_WAIT_BSY: begin
                if (bus.wr_busy) begin
                    state_nxt = F_WAIT_DONE;
                end else if (bsy_tmo == TMO_LAST) begin
                    state_nxt = F_ISSUE;
                end
            end
            F_WAIT_DONE: begin
                if (!bus.wr_busy) begin
                    state_nxt = F_ADV;
                end
            end
            F_ADV: begin
                state_nxt = F_IDLE;
            end
            default: begin
                state_nxt = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= F_IDLE;
            bsy_tmo     <= 4'd0;
            bus.wr_addr <= START_ADDR;
            sector_cnt  <= 32'd0;
            overflow    <= 1'b0;
            log_full    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bsy_tmo <= (state == F_WAIT_BSY) ? bsy_tmo + 4'd1 : 4'd0;
            if (state == F_ADV) begin
                bus.wr_addr <= bus.wr_addr + 32'd1;
                sector_cnt  <= sector_cnt + 32'd1;
                if (sector_cnt + 32'd1 == MAX_SECTORS) begin
                    log_full <= 1'b1;
                end
            end
            if (drop || underrun) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_feeder.sv
// tb/tb_sd_sector_feeder.sv - self-checking bench for sd_sector_feeder
module tb_sd_sector_feeder;
    import sd_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic        init_end_v  [2];
    logic        din_valid_v [2];
    logic [15:0] din_v       [2];
    logic        man         [2];
    logic        man_req     [2];
    logic        deaf        [2];
    logic        stall       [2];
    logic        m_busy      [2];
    logic        m_req       [2];
    logic        m_ph        [2];
    int          m_nreq      [2];
    int          m_nrx       [2];
    int          rx_total    [2];
    int          en_cnt      [2];
    logic [31:0] en_addr     [2][8];

    logic        din_ready_o [2];
    logic        wr_en_o     [2];
    logic        ovf_o       [2];
    logic        lfull_o     [2];
    logic [31:0] wr_addr_o   [2];
    logic [15:0] wr_data_o   [2];

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    int checks = 0;
    int errors = 0;

    sd_sector_feeder_if bus0 ();
    sd_sector_feeder_if bus1 ();

    assign bus0.din_valid = din_valid_v[0];
    assign bus0.din       = din_v[0];
    assign bus0.wr_busy   = m_busy[0];
    assign bus0.wr_req    = man[0] ? man_req[0] : m_req[0];
    assign bus1.din_valid = din_valid_v[1];
    assign bus1.din       = din_v[1];
    assign bus1.wr_busy   = m_busy[1];
    assign bus1.wr_req    = man[1] ? man_req[1] : m_req[1];

    assign din_ready_o[0] = bus0.din_ready;
    assign wr_en_o[0]     = bus0.wr_en;
    assign wr_addr_o[0]   = bus0.wr_addr;
    assign wr_data_o[0]   = bus0.wr_data;
    assign din_ready_o[1] = bus1.din_ready;
    assign wr_en_o[1]     = bus1.wr_en;
    assign wr_addr_o[1]   = bus1.wr_addr;
    assign wr_data_o[1]   = bus1.wr_data;

    sd_sector_feeder dut0 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .init_end (init_end_v[0]),
        .bus      (bus0),
        .overflow (ovf_o[0]),
        .log_full (lfull_o[0])
    );

    sd_sector_feeder #(.MAX_SECTORS(32'd2)) dut1 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .init_end (init_end_v[1]),
        .bus      (bus1),
        .overflow (ovf_o[1]),
        .log_full (lfull_o[1])
    );

    typedef struct {
        int   n;
        logic exp_ready;
        logic exp_ovf;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Writer model: busy rises after wr_en, one pop every other cycle, idle after 256 words.
    task automatic model_step();
        for (int g = 0; g < 2; g++) begin
            if (sys_rst) begin
                m_busy[g] = 1'b0;
                m_req[g]  = 1'b0;
                m_ph[g]   = 1'b0;
                m_nreq[g] = 0;
                m_nrx[g]  = 0;
            end else begin
                if (wr_en_o[g]) begin
                    if (en_cnt[g] < 8) en_addr[g][en_cnt[g]] = wr_addr_o[g];
                    en_cnt[g]++;
                end
                if (m_req[g]) begin
                    rx_total[g]++;
                    m_nrx[g]++;
                    if (g == 0) begin
                        if (exp_q0.size() == 0) fail_to("rx0_unexpected");
                        else chk("rx_data0", 32'(wr_data_o[0]), 32'(exp_q0.pop_front()));
                    end else begin
                        if (exp_q1.size() == 0) fail_to("rx1_unexpected");
                        else chk("rx_data1", 32'(wr_data_o[1]), 32'(exp_q1.pop_front()));
                    end
                end
                m_req[g] = 1'b0;
                if (!m_busy[g]) begin
                    if (wr_en_o[g] && !deaf[g]) begin
                        m_busy[g] = 1'b1;
                        m_nreq[g] = 0;
                        m_nrx[g]  = 0;
                        m_ph[g]   = 1'b0;
                    end
                end else if (!stall[g]) begin
                    if (m_nrx[g] == SECTOR_WORDS_DEF) begin
                        m_busy[g] = 1'b0;
                    end else if (m_nreq[g] < SECTOR_WORDS_DEF) begin
                        if (m_ph[g]) begin
                            m_req[g] = 1'b1;
                            m_nreq[g]++;
                        end
                        m_ph[g] = !m_ph[g];
                    end
                end
            end
        end
    endtask

    task automatic push(input int g, input int n, input int base, input bit wait_rdy);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (wait_rdy && !din_ready_o[g] && t < 3000) begin
                din_valid_v[g] = 1'b0;
                @(posedge sys_clk); #1;
                t++;
            end
            if (t >= 3000) begin
                fail_to("push_ready");
                break;
            end
            din_valid_v[g] = 1'b1;
            din_v[g]       = 16'(base + i);
            if (din_ready_o[g]) begin
                if (g == 0) exp_q0.push_back(16'(base + i));
                else        exp_q1.push_back(16'(base + i));
            end
            @(posedge sys_clk); #1;
        end
        din_valid_v[g] = 1'b0;
    endtask

    task automatic wait_rx(input int g, input int target);
        int t;
        t = 0;
        while (rx_total[g] < target && t < 5000) begin
            @(posedge sys_clk); #1;
            t++;
        end
        if (rx_total[g] < target) fail_to("wait_rx");
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        en_cnt[0] = 0;
        en_cnt[1] = 0;
    endtask

    initial begin
        int base;
        int lat;
        int rx0;
        for (int g = 0; g < 2; g++) begin
            init_end_v[g] = 1'b0; din_valid_v[g] = 1'b0; din_v[g] = 16'h0;
            man[g] = 1'b0; man_req[g] = 1'b0; deaf[g] = 1'b0; stall[g] = 1'b0;
            m_busy[g] = 1'b0; m_req[g] = 1'b0; m_ph[g] = 1'b0;
            m_nreq[g] = 0; m_nrx[g] = 0; rx_total[g] = 0; en_cnt[g] = 0;
            for (int k = 0; k < 8; k++) en_addr[g][k] = 32'h0;
        end
        fork
            forever begin
                @(negedge sys_clk);
                model_step();
            end
        join_none

        // Reset values
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_din_ready", 32'(din_ready_o[0]), 32'd1);
        chk("rst_wr_en", 32'(wr_en_o[0]), 32'd0);
        chk("rst_wr_addr", wr_addr_o[0], 32'd2048);
        chk("rst_wr_data", 32'(wr_data_o[0]), 32'h0);
        chk("rst_overflow", 32'(ovf_o[0]), 32'd0);
        chk("rst_log_full", 32'(lfull_o[0]), 32'd0);
        sys_rst = 1'b0;

        // One sector end to end
        init_end_v[0] = 1'b1;
        push(0, 256, 16'h0000, 1'b1);
        wait_rx(0, 256);
        chk("t1_en_count", 32'(en_cnt[0]), 32'd1);
        chk("t1_en_addr", en_addr[0][0], 32'd2048);
        chk("t1_sb_empty", 32'(exp_q0.size()), 32'd0);
        chk("t1_addr_after", wr_addr_o[0], 32'd2049);

        // 255 words do not trigger; the 256th does within 2 cycles
        push(0, 255, 16'h0100, 1'b1);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("t2_no_en_255", 32'(en_cnt[0]), 32'd1);
        push(0, 1, 16'h01FF, 1'b1);
        lat = 0;
        while (lat < 3 && !wr_en_o[0]) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        chk("t2_en_latency_ok", 32'(wr_en_o[0] && lat <= 2), 32'd1);
        wait_rx(0, 512);
        chk("t2_en_addr", en_addr[0][1], 32'd2049);
        chk("t2_sb_empty", 32'(exp_q0.size()), 32'd0);

        // Fill with init_end low: table of bursts and expected flags
        do_reset();
        init_end_v[0] = 1'b0;
        vecs[0] = '{100, 1'b1, 1'b0};
        vecs[1] = '{155, 1'b1, 1'b0};
        vecs[2] = '{256, 1'b1, 1'b0};
        vecs[3] = '{1,   1'b0, 1'b0};
        vecs[4] = '{3,   1'b0, 1'b1};
        base = 16'h1000;
        for (int v = 0; v < 5; v++) begin
            push(0, vecs[v].n, base, 1'b0);
            base += vecs[v].n;
            chk($sformatf("tbl%0d_din_ready", v), 32'(din_ready_o[0]), 32'(vecs[v].exp_ready));
            chk($sformatf("tbl%0d_overflow", v), 32'(ovf_o[0]), 32'(vecs[v].exp_ovf));
            chk($sformatf("tbl%0d_no_en", v), 32'(en_cnt[0]), 32'd0);
        end

        // Pop and push in the same cycle while full
        man[0] = 1'b1;
        man_req[0] = 1'b1;
        din_valid_v[0] = 1'b1;
        din_v[0] = 16'hABCD;
        @(posedge sys_clk); #1;
        man_req[0] = 1'b0;
        din_valid_v[0] = 1'b0;
        man[0] = 1'b0;
        chk("t4_pop_head", 32'(wr_data_o[0]), 32'(exp_q0.pop_front()));
        exp_q0.push_back(16'hABCD);
        chk("t4_still_full", 32'(din_ready_o[0]), 32'd0);
        chk("t4_overflow_kept", 32'(ovf_o[0]), 32'd1);

        // Release init_end: two back-to-back sectors
        rx0 = rx_total[0];
        init_end_v[0] = 1'b1;
        wait_rx(0, rx0 + 512);
        chk("t3_en_count", 32'(en_cnt[0]), 32'd2);
        chk("t3_addr0", en_addr[0][0], 32'd2048);
        chk("t3_addr1", en_addr[0][1], 32'd2049);
        chk("t3_sb_empty", 32'(exp_q0.size()), 32'd0);
        chk("t3_addr_after", wr_addr_o[0], 32'd2050);

        // Writer never answers: wr_en re-pulses, address holds
        base = en_cnt[0];
        deaf[0] = 1'b1;
        push(0, 256, 16'h3000, 1'b1);
        repeat (40) @(posedge sys_clk);
        #1;
        chk("tmo_repulse", 32'((en_cnt[0] - base) >= 2), 32'd1);
        chk("tmo_addr_a", en_addr[0][base], 32'd2050);
        chk("tmo_addr_b", en_addr[0][base + 1], 32'd2050);
        deaf[0] = 1'b0;
        rx0 = rx_total[0];
        wait_rx(0, rx0 + 256);
        chk("tmo_sb_empty", 32'(exp_q0.size()), 32'd0);
        chk("tmo_addr_after", wr_addr_o[0], 32'd2051);

        // Reset while waiting for the writer with words pending
        stall[0] = 1'b1;
        push(0, 256, 16'h6000, 1'b1);
        repeat (6) @(posedge sys_clk);
        #1;
        push(0, 3, 16'h6100, 1'b1);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        chk("t6_din_ready", 32'(din_ready_o[0]), 32'd1);
        chk("t6_wr_en", 32'(wr_en_o[0]), 32'd0);
        chk("t6_wr_addr", wr_addr_o[0], 32'd2048);
        chk("t6_wr_data", 32'(wr_data_o[0]), 32'h0);
        chk("t6_overflow", 32'(ovf_o[0]), 32'd0);
        chk("t6_log_full", 32'(lfull_o[0]), 32'd0);
        sys_rst = 1'b0;
        stall[0] = 1'b0;
        exp_q0.delete();
        en_cnt[0] = 0;
        en_cnt[1] = 0;
        repeat (20) @(posedge sys_clk);
        #1;
        chk("t6_no_partial", 32'(en_cnt[0]), 32'd0);
        rx0 = rx_total[0];
        push(0, 256, 16'h7000, 1'b1);
        wait_rx(0, rx0 + 256);
        chk("t6_fresh_addr", en_addr[0][0], 32'd2048);
        chk("t6_sb_empty", 32'(exp_q0.size()), 32'd0);

        // Sector limit of 2 on the second instance
        init_end_v[1] = 1'b1;
        push(1, 768, 16'h8000, 1'b1);
        wait_rx(1, 512);
        repeat (20) @(posedge sys_clk);
        #1;
        chk("t5_en_count", 32'(en_cnt[1]), 32'd2);
        chk("t5_addr0", en_addr[1][0], 32'd2048);
        chk("t5_addr1", en_addr[1][1], 32'd2049);
        chk("t5_log_full", 32'(lfull_o[1]), 32'd1);
        chk("t5_wr_addr", wr_addr_o[1], 32'd2050);
        chk("t5_left", 32'(exp_q1.size()), 32'd256);
        push(1, 256, 16'h9000, 1'b0);
        chk("t5_fills_at_256", 32'(din_ready_o[1]), 32'd0);
        chk("t5_no_ovf_yet", 32'(ovf_o[1]), 32'd0);
        push(1, 1, 16'h9100, 1'b0);
        chk("t5_ovf", 32'(ovf_o[1]), 32'd1);
        chk("t5_no_more_en", 32'(en_cnt[1]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
